bcdd_seq_ctrl: RTL and testbench

- Sequencing controller for the 4-bit BCD-to-decimal decoder (inputs A..D, one-hot outputs E0..E9).
- Owns the digit driven into the decoder and supports four operations: load a value, count up, count down, and a self-test sweep.
- The self-test sweep drives 0..9 in turn and checks the decoder's one-hot response.
- Sits between the lab top level (switches/buttons) and the decoder instance; replaces free-running testbench toggling with a clocked, checkable source.

---
 rtl/bcdd_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_bcdd_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcdd_seq_ctrl.sv
// Clocked digit source for the BCD-to-decimal decoder: load, count up/down,
// and a self-test sweep that checks the decoder's one-hot response.
module bcdd_seq_ctrl #(
    parameter int unsigned DIV    = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [3:0] load_val,
    input  logic       stop,
    input  logic       clr_err,
    input  logic [9:0] E,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       busy,
    output logic       done,
    output logic       carry,
    output logic       borrow,
    output logic       err,
    output logic [3:0] err_cnt,
    output logic [3:0] err_digit
);

    localparam logic [7:0] DIV_LAST    = 8'(DIV - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t     state;
    logic [3:0] digit;
    logic [7:0] presc;
    logic [3:0] settle_cnt;
    logic       dir_down;

    logic [9:0] expect_e;
    logic       illegal_load;
    logic       mismatch;
    logic       err_event;

    assign {A, B, C, D} = digit;

    always_comb begin
        expect_e     = 10'd1 << digit;
        illegal_load = (state == S_IDLE) && start && (mode == 2'b10) && (load_val > 4'd9);
        mismatch     = (state == S_CHECK) && (E != expect_e);
        err_event    = illegal_load || mismatch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            digit      <= '0;
            presc      <= '0;
            settle_cnt <= '0;
            dir_down   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            carry      <= 1'b0;
            borrow     <= 1'b0;
        end else begin
            done   <= 1'b0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (mode)
                            2'b00, 2'b01: begin
                                state    <= S_RUN;
                                presc    <= '0;
                                dir_down <= mode[0];
                                busy     <= 1'b1;
                            end
                            2'b10: begin
                                if (load_val <= 4'd9)
                                    digit <= load_val;
                                done <= 1'b1;
                            end
                            default: begin
                                state      <= S_SETTLE;
                                digit      <= '0;
                                settle_cnt <= '0;
                                busy       <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    // stop takes priority over a coinciding terminal count
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (presc == DIV_LAST) begin
                        presc <= '0;
                        if (!dir_down) begin
                            if (digit == 4'd9) begin
                                digit <= '0;
                                carry <= 1'b1;
                            end else begin
                                digit <= digit + 4'd1;
                            end
                        end else begin
                            if (digit == 4'd0) begin
                                digit  <= 4'd9;
                                borrow <= 1'b1;
                            end else begin
                                digit <= digit - 4'd1;
                            end
                        end
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST)
                        state <= S_CHECK;
                    else
                        settle_cnt <= settle_cnt + 4'd1;
                end
                S_CHECK: begin
                    if (digit == 4'd9) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        digit      <= digit + 4'd1;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A new error outranks a simultaneous clear and restarts the record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            err_cnt   <= '0;
            err_digit <= '0;
        end else if (err_event) begin
            err <= 1'b1;
            if (clr_err || !err)
                err_digit <= digit;
            if (clr_err)
                err_cnt <= 4'd1;
            else if (err_cnt != 4'hF)
                err_cnt <= err_cnt + 4'd1;
        end else if (clr_err) begin
            err       <= 1'b0;
            err_cnt   <= '0;
            err_digit <= '0;
        end
    end

endmodule

// File: tb/tb_bcdd_seq_ctrl.sv
// Self-checking bench for bcdd_seq_ctrl: load table, directed corner
// sequences, and randomized commands against an arithmetic reference model.
module tb_bcdd_seq_ctrl;

    localparam int DIV_P    = 4;
    localparam int SETTLE_P = 2;
    localparam int SWEEP_LEN = 10 * (SETTLE_P + 1);

    logic       clk;
    logic       rst_n;
    logic       start, stop, clr_err;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic [9:0] E;
    logic       A, B, C, D, busy, done, carry, borrow, err;
    logic [3:0] err_cnt, err_digit;
    logic [3:0] dig;

    logic       start2, stop2;
    logic [1:0] mode2;
    logic [9:0] E2;
    logic       A2, B2, C2, D2, busy2, done2, carry2, borrow2, err2;
    logic [3:0] err_cnt2, err_digit2;
    logic [3:0] dig2;

    logic [9:0] stuck_low, stuck_high;

    int checks = 0;
    int failures = 0;
    int carry_n, borrow_n, done_n, excl_bad;

    bcdd_seq_ctrl #(.DIV(DIV_P), .SETTLE(SETTLE_P)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .load_val(load_val),
        .stop(stop), .clr_err(clr_err), .E(E), .A(A), .B(B), .C(C), .D(D),
        .busy(busy), .done(done), .carry(carry), .borrow(borrow), .err(err),
        .err_cnt(err_cnt), .err_digit(err_digit)
    );

    bcdd_seq_ctrl #(.DIV(1), .SETTLE(SETTLE_P)) u_dut_div1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .load_val(load_val),
        .stop(stop2), .clr_err(1'b0), .E(E2), .A(A2), .B(B2), .C(C2), .D(D2),
        .busy(busy2), .done(done2), .carry(carry2), .borrow(borrow2), .err(err2),
        .err_cnt(err_cnt2), .err_digit(err_digit2)
    );

    assign dig  = {A, B, C, D};
    assign dig2 = {A2, B2, C2, D2};

    // Decoder model with optional stuck bits
    always_comb begin
        E  = ((10'd1 << dig) & ~stuck_low) | stuck_high;
        E2 = 10'd1 << dig2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            carry_n  += int'(carry);
            borrow_n += int'(borrow);
            done_n   += int'(done);
            if (int'(carry) + int'(borrow) + int'(done) > 1) excl_bad++;
        end
    end

    typedef struct {
        logic [3:0] lv;
        int exp_digit;
        int exp_err;
        int exp_cnt;
        int exp_edig;
    } load_vec_t;

    load_vec_t tbl[6];

    int m_digit, m_err, m_cnt, m_edig;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        start = 1'b1; mode = 2'b10; load_val = v;
        tick;
        start = 1'b0;
    endtask

    task automatic m_error(input int d);
        if (m_err == 0) m_edig = d;
        m_err = 1;
        if (m_cnt < 15) m_cnt++;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_digit"}, int'(dig), m_digit);
        chk({tag, "_err"}, int'(err), m_err);
        chk({tag, "_err_cnt"}, int'(err_cnt), m_cnt);
        chk({tag, "_err_digit"}, int'(err_digit), m_edig);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // clr_at, if nonzero, is the edge (3d+3) on which clr_err meets digit d's check
    task automatic run_sweep(input int clr_at);
        start = 1'b1; mode = 2'b11;
        tick;
        start = 1'b0;
        chk("sweep_start_digit", int'(dig), 0);
        for (int k = 1; k <= SWEEP_LEN; k++) begin
            if (k == clr_at) clr_err = 1'b1;
            tick;
            clr_err = 1'b0;
            chk("sweep_digit", int'(dig), (k < SWEEP_LEN) ? k / (SETTLE_P + 1) : 9);
            chk("sweep_done", int'(done), int'(k == SWEEP_LEN));
            chk("sweep_busy", int'(busy), int'(k < SWEEP_LEN));
            if (k == clr_at) begin
                chk("clr_coincident_cnt", int'(err_cnt), 1);
                chk("clr_coincident_digit", int'(err_digit), k / (SETTLE_P + 1) - 1);
            end
        end
        tick;
        chk("sweep_done_clear", int'(done), 0);
    endtask

    initial begin
        int steps, k, op, v, d0;
        logic [9:0] e_exp;

        rst_n = 1'b0; start = 0; stop = 0; clr_err = 0; mode = 0; load_val = 0;
        start2 = 0; stop2 = 0; mode2 = 0; stuck_low = '0; stuck_high = '0;
        carry_n = 0; borrow_n = 0; done_n = 0; excl_bad = 0;

        tbl[0] = '{4'd7,  7, 0, 0, 0};
        tbl[1] = '{4'd12, 7, 1, 1, 7};
        tbl[2] = '{4'd0,  0, 1, 1, 7};
        tbl[3] = '{4'd15, 0, 1, 2, 7};
        tbl[4] = '{4'd9,  9, 1, 2, 7};
        tbl[5] = '{4'd10, 9, 1, 3, 7};

        #12;
        chk("rst_digit", int'(dig), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) begin
            do_load(tbl[i].lv);
            chk("load_done", int'(done), 1);
            chk("load_digit", int'(dig), tbl[i].exp_digit);
            chk("load_err", int'(err), tbl[i].exp_err);
            chk("load_err_cnt", int'(err_cnt), tbl[i].exp_cnt);
            chk("load_err_digit", int'(err_digit), tbl[i].exp_edig);
            tick;
            chk("load_done_pulse", int'(done), 0);
        end

        clr_err = 1'b1; tick; clr_err = 1'b0;
        chk("clr_err", int'(err), 0);
        chk("clr_err_cnt", int'(err_cnt), 0);
        chk("clr_err_digit", int'(err_digit), 0);

        // UP from 8 with DIV=4; stop lands on the third terminal count
        do_load(4'd8); tick;
        start = 1'b1; mode = 2'b00; tick; start = 1'b0;
        for (int kk = 1; kk <= 12; kk++) begin
            if (kk == 12) stop = 1'b1;
            tick;
            stop = 1'b0;
            chk("up_digit", int'(dig), (kk < 4) ? 8 : (kk < 8) ? 9 : 0);
            chk("up_carry", int'(carry), int'(kk == 8));
            chk("up_busy", int'(busy), int'(kk < 12));
        end
        tick;
        chk("up_stop_digit", int'(dig), 0);
        chk("up_stop_busy", int'(busy), 0);

        // DOWN from 1 with DIV=1
        load_val = 4'd1; start2 = 1'b1; mode2 = 2'b10; tick; start2 = 1'b0;
        chk("dn_load", int'(dig2), 1);
        start2 = 1'b1; mode2 = 2'b01; tick; start2 = 1'b0;
        for (int kk = 1; kk <= 3; kk++) begin
            tick;
            chk("dn_digit", int'(dig2), (kk == 1) ? 0 : (kk == 2) ? 9 : 8);
            chk("dn_borrow", int'(borrow2), int'(kk == 2));
            chk("dn_busy", int'(busy2), 1);
        end
        stop2 = 1'b1; tick; stop2 = 1'b0;
        chk("dn_stop_digit", int'(dig2), 8);
        chk("dn_stop_busy", int'(busy2), 0);

        // Ideal sweep
        run_sweep(0);
        chk("sweep_ideal_err", int'(err), 0);

        // E4 and E9 stuck low
        stuck_low = 10'b10_0001_0000;
        run_sweep(0);
        chk("stuck_err", int'(err), 1);
        chk("stuck_err_cnt", int'(err_cnt), 2);
        chk("stuck_err_digit", int'(err_digit), 4);
        clr_err = 1'b1; tick; clr_err = 1'b0;
        chk("stuck_clr_err", int'(err), 0);
        chk("stuck_clr_cnt", int'(err_cnt), 0);
        chk("stuck_clr_digit", int'(err_digit), 0);

        // E2, E4 stuck; clear meets the digit-4 mismatch
        stuck_low = 10'b00_0001_0100;
        run_sweep(3 * (SETTLE_P + 1) * 4 / 3 + 3);
        chk("coinc_err", int'(err), 1);
        chk("coinc_err_cnt", int'(err_cnt), 1);
        chk("coinc_err_digit", int'(err_digit), 4);
        stuck_low = '0;

        // Randomized commands against the reference model
        clr_err = 1'b1; tick; clr_err = 1'b0;
        do_load(4'd0); tick;
        m_digit = 0; m_err = 0; m_cnt = 0; m_edig = 0;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            carry_n = 0; borrow_n = 0; done_n = 0;
            case (op)
                0: begin
                    v = $urandom_range(0, 15);
                    if (v <= 9) m_digit = v; else m_error(m_digit);
                    do_load(4'(v)); tick;
                    chk("rnd_load_done_n", done_n, 1);
                end
                1, 2: begin
                    k = $urandom_range(1, 40);
                    d0 = m_digit;
                    steps = (k - 1) / DIV_P;
                    start = 1'b1; mode = (op == 1) ? 2'b00 : 2'b01; tick; start = 1'b0;
                    repeat (k - 1) tick;
                    stop = 1'b1; tick; stop = 1'b0;
                    tick;
                    if (op == 1) begin
                        m_digit = (d0 + steps) % 10;
                        chk("rnd_up_carries", carry_n, (d0 + steps) / 10);
                        chk("rnd_up_borrows", borrow_n, 0);
                    end else begin
                        m_digit = ((d0 - steps) % 10 + 10) % 10;
                        chk("rnd_dn_borrows", borrow_n, (steps > d0) ? (steps - d0 - 1) / 10 + 1 : 0);
                        chk("rnd_dn_carries", carry_n, 0);
                    end
                end
                3: begin
                    stuck_low  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 1023)) : '0;
                    stuck_high = ($urandom_range(0, 3) == 0) ? (10'd1 << $urandom_range(0, 9)) : '0;
                    for (int d = 0; d < 10; d++) begin
                        e_exp = ((10'd1 << d) & ~stuck_low) | stuck_high;
                        if (e_exp != (10'd1 << d)) m_error(d);
                    end
                    m_digit = 9;
                    run_sweep(0);
                    chk("rnd_sweep_done_n", done_n, 1);
                    stuck_low = '0; stuck_high = '0;
                end
                default: begin
                    m_err = 0; m_cnt = 0; m_edig = 0;
                    clr_err = 1'b1; tick; clr_err = 1'b0;
                end
            endcase
            chk_model("rnd");
        end

        // Asynchronous reset mid-run at digit 6
        do_load(4'd13); tick;
        do_load(4'd6); tick;
        start = 1'b1; mode = 2'b00; tick; start = 1'b0;
        tick;
        chk("pre_rst_digit", int'(dig), 6);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_err_cnt_nz", int'(err_cnt != 0), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_digit", int'(dig), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_err_cnt", int'(err_cnt), 0);
        chk("async_rst_err", int'(err), 0);
        tick;
        rst_n = 1'b1;
        tick; tick;
        chk("post_rst_digit", int'(dig), 0);
        chk("post_rst_busy", int'(busy), 0);

        chk("pulse_exclusive", excl_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
